// File: rtl/f_sweep_ctrl.sv
// In-system sweep of the 4-input function block f: walks all 16 vectors, samples s,
// and compares the measured truth table with a golden mask captured at start.
module f_sweep_ctrl #(
  parameter int SETTLE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] expected,
  input  logic        s_in,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic        busy,
  output logic        done,
  output logic [15:0] table_out,
  output logic [4:0]  err_count,
  output logic [3:0]  first_fail,
  output logic        fail_valid,
  output logic        match
);

  typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, DONE} state_t;

  localparam logic [3:0] RELOAD = 4'(SETTLE - 1);

  state_t      state, state_nx;
  logic [3:0]  idx, idx_nx;
  logic [3:0]  wcnt, wcnt_nx;
  logic [15:0] mask, mask_nx;
  logic [15:0] table_nx;
  logic [4:0]  err_nx;
  logic [3:0]  first_nx;
  logic        match_nx;
  logic        sweeping;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= 4'd0;
      wcnt       <= 4'd0;
      mask       <= 16'd0;
      table_out  <= 16'd0;
      err_count  <= 5'd0;
      first_fail <= 4'd0;
      match      <= 1'b0;
    end else begin
      state      <= state_nx;
      idx        <= idx_nx;
      wcnt       <= wcnt_nx;
      mask       <= mask_nx;
      table_out  <= table_nx;
      err_count  <= err_nx;
      first_fail <= first_nx;
      match      <= match_nx;
    end
  end

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    wcnt_nx  = wcnt;
    mask_nx  = mask;
    table_nx = table_out;
    err_nx   = err_count;
    first_nx = first_fail;
    match_nx = match;
    case (state)
      IDLE: begin
        if (start) begin
          mask_nx  = expected;
          table_nx = 16'd0;
          err_nx   = 5'd0;
          first_nx = 4'd0;
          match_nx = 1'b0;
          idx_nx   = 4'd0;
          wcnt_nx  = RELOAD;
          state_nx = APPLY;
        end
      end
      APPLY: begin
        if (wcnt == 4'd0) state_nx = SAMPLE;
        else              wcnt_nx  = wcnt - 4'd1;
      end
      SAMPLE: begin
        table_nx[idx] = s_in;
        if (s_in != mask[idx]) begin
          err_nx = err_count + 5'd1;
          // Only the first mismatch of the sweep records its index.
          if (err_count == 5'd0) first_nx = idx;
        end
        if (idx == 4'd15) begin
          state_nx = DONE;
        end else begin
          idx_nx   = idx + 4'd1;
          wcnt_nx  = RELOAD;
          state_nx = APPLY;
        end
      end
      DONE: begin
        match_nx = (err_count == 5'd0);
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Every output below decodes registered state only.
  assign sweeping     = (state == APPLY) || (state == SAMPLE);
  assign {a, b, c, d} = sweeping ? idx : 4'd0;
  assign busy         = sweeping;
  assign done         = (state == DONE);
  assign fail_valid   = (err_count != 5'd0);

endmodule

// File: doc/f_sweep_ctrl.md
# f_sweep_ctrl

Sequencer that exhaustively exercises the team's 4-input combinational function block `f` (inputs a, b, c, d; output s) in-system. On a start request it walks all 16 input combinations, waits a programmable settle time, samples s, builds the measured 16-bit truth table and compares it against a golden mask latched at start. It sits between `f` and the self-test/status logic and reports pass/fail, error count and first failing vector.

## Interface
Parameters:
- SETTLE, default 1: cycles each vector is held before sampling; legal range 1..15.

Ports (one clock; reset is synchronous and active-high):
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  sweep request; sampled only in IDLE
- expected  input  16  golden truth table; bit i = required s for vector i; latched on accepted start
- s_in  input  1  output s of `f`
- a, b, c, d  output  1 each  drive to `f`; {a,b,c,d} = current vector index, a is MSB
- busy  output  1  high from the cycle after an accepted start through the last SAMPLE cycle
- done  output  1  one-cycle pulse when the sweep completes
- table_out  output  16  measured truth table; bit i = sampled s_in for vector i
- err_count  output  5  number of mismatching vectors, 0..16
- first_fail  output  4  index of lowest mismatching vector
- fail_valid  output  1  high when err_count != 0
- match  output  1  high when the last completed sweep had err_count == 0

## Operation
- States: IDLE, APPLY, SAMPLE, DONE; 4-bit vector index idx; settle counter wcnt.
- Reset (any state, including mid-sweep): state=IDLE, idx=0, {a,b,c,d}=0000, busy=0, done=0, table_out=0, err_count=0, first_fail=0, fail_valid=0, match=0, latched mask=0.
- IDLE: {a,b,c,d}=0000. On start=1: latch expected, clear table_out, err_count, first_fail, fail_valid and match; set idx=0, wcnt=SETTLE-1; go to APPLY.
- APPLY: drive {a,b,c,d}=idx. If wcnt==0, go to SAMPLE; else decrement wcnt.
- SAMPLE: vector still driven. Set table_out[idx]=s_in. If s_in != mask[idx]: increment err_count; if fail_valid was 0, set first_fail=idx and fail_valid=1. If idx==15, go to DONE; else increment idx, reload wcnt=SETTLE-1 and go to APPLY.
- DONE: done=1 for exactly this cycle; match=(err_count==0) registered on entry to IDLE and held; {a,b,c,d}=0000; next state is IDLE.
- A start while not in IDLE is ignored, with no effect on the current sweep or the latched mask. A start during the DONE cycle is also ignored.
- Changes to `expected` after an accepted start have no effect until the next start.
- table_out, err_count, first_fail, fail_valid and match hold their values in IDLE until the next accepted start or reset.
- err_count saturates naturally at 16; no wrap-around is possible.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- Start sampled high at edge 0: busy is high from edge 0, and APPLY for vector 0 begins.
- Each vector lasts SETTLE+1 cycles: SETTLE cycles in APPLY and 1 cycle in SAMPLE. s_in is sampled at the end of the SAMPLE cycle.
- done is high in the cycle after edge 16*(SETTLE+1), i.e. edge 32 for SETTLE=1. busy falls on that same edge.
- match and final status are valid from the cycle after done and held thereafter.
- Back-to-back operation: the earliest next start is accepted in the first IDLE cycle after done.

## Test plan
- Nominal sweep: SETTLE=1, `f` connected, expected=16'h212F -> table_out=16'h212F, err_count=0, fail_valid=0, match=1, done pulse in the cycle after edge 32.
- Single mismatch: expected=16'h212E -> err_count=1, first_fail=0, fail_valid=1, match=0, table_out=16'h212F.
- All mismatch: expected=16'hDED0 -> err_count=16, first_fail=0, match=0.
- Ignored start and mask change: pulse start and change expected to 16'h0000 at edge 10 of a running sweep -> the sweep is unaffected, and done still occurs after edge 32 with match=1.
- Reset mid-sweep: assert reset at edge 12 -> the next cycle shows all outputs at reset values and state IDLE. A subsequent start runs a full, correct sweep.
- SETTLE=3: start at edge 0 -> {a,b,c,d}=0001 during edges 4..7, done after edge 64. Force s_in=0 only on vector 5 with expected=16'h212F -> err_count=1, first_fail=5.
